trail_ram_arbiter: RTL and testbench

//  Per-tick RAM sequencer for the trail grid. On each game tick it visits every

---
 rtl/trail_ram_arbiter_pkg.sv | 24 ++
 rtl/trail_collide.sv | 30 +++
 rtl/trail_ram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_trail_ram_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/trail_ram_arbiter_pkg.sv
// Shared definitions for the trail grid RAM sequencer: state encoding, tile colours
// and slot-slice helpers for the packed pos/tiles buses.
package trail_ram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CK   = 3'd2,
        ST_WR   = 3'd3,
        ST_NEXT = 3'd4,
        ST_CLR  = 3'd5
    } arb_state_t;

    localparam int EMPTY        = 0;
    localparam int DEF_X_BITS   = 8;
    localparam int DEF_Y_BITS   = 7;
    localparam int DEF_ADDR_W   = DEF_X_BITS + DEF_Y_BITS;

    // Bit offset of slot 'slot' inside a packed bus of 'width'-bit fields.
    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/trail_collide.sv
// Head-on detector: flags when the current slot shares its snapshot position
// with any other alive snapshot slot.
module trail_collide
    import trail_ram_arbiter_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_PLAYERS*ADDR_W-1:0] pos_snap,
    input  logic [NUM_PLAYERS-1:0]        alive_snap,
    input  logic [IDX_W-1:0]              idx,
    output logic                          head_on
);

    logic [ADDR_W-1:0]      own_pos;
    logic [NUM_PLAYERS-1:0] match;

    assign own_pos = pos_snap[idx*ADDR_W +: ADDR_W];

    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_cmp
            assign match[gi] = alive_snap[gi] && (IDX_W'(gi) != idx) &&
                               (pos_snap[slot_lsb(gi, ADDR_W) +: ADDR_W] == own_pos);
        end
    endgenerate

    assign head_on = |match;

endmodule

// File: rtl/trail_ram_arbiter.sv
// Per-tick tile RAM sequencer: read/check/paint each player slot in turn, and sweep
// the whole grid to EMPTY when a clear has been requested.
module trail_ram_arbiter
    import trail_ram_arbiter_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOUR_BITS = 3,
    parameter int X_MAX       = 159,
    parameter int Y_MAX       = 119
) (
    input  logic                                     CLOCK_50,
    input  logic                                     resetn,
    input  logic                                     tick,
    input  logic                                     clear_req,
    input  logic [NUM_PLAYERS*(X_BITS+Y_BITS)-1:0]   pos,
    input  logic [NUM_PLAYERS-1:0]                   alive,
    output logic [X_BITS+Y_BITS-1:0]                 address,
    output logic [COLOUR_BITS-1:0]                   data,
    output logic                                     wren,
    input  logic [COLOUR_BITS-1:0]                   q,
    output logic [NUM_PLAYERS-1:0]                   kill,
    output logic [NUM_PLAYERS*(X_BITS+Y_BITS+1)-1:0] tiles,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     overrun
);

    localparam int AW    = X_BITS + Y_BITS;
    localparam int TW    = AW + 1;
    localparam int IW    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam logic [X_BITS-1:0]      X_LIM   = X_BITS'(X_MAX);
    localparam logic [Y_BITS-1:0]      Y_LIM   = Y_BITS'(Y_MAX);
    localparam logic [COLOUR_BITS-1:0] EMPTY_C = COLOUR_BITS'(EMPTY);
    localparam logic [IW-1:0]          LAST    = IW'(NUM_PLAYERS - 1);

    arb_state_t                state_reg;
    logic [IW-1:0]             idx_reg;
    logic [NUM_PLAYERS*AW-1:0] pos_snap_reg;
    logic [NUM_PLAYERS-1:0]    alive_snap_reg;
    logic                      clear_pending_reg;
    logic [TW-1:0]             tiles_reg [NUM_PLAYERS];

    logic [AW-1:0]     cur_pos;
    logic [X_BITS-1:0] cur_x;
    logic [Y_BITS-1:0] cur_y;
    logic [IW-1:0]     idx_next;
    logic              head_on;
    logic              out_of_bounds;
    logic              dying;

    assign cur_pos       = pos_snap_reg[idx_reg*AW +: AW];
    assign cur_x         = cur_pos[AW-1 -: X_BITS];
    assign cur_y         = cur_pos[Y_BITS-1:0];
    assign idx_next      = idx_reg + IW'(1);
    assign out_of_bounds = (cur_x > X_LIM) || (cur_y > Y_LIM);
    // Evaluated in CK, when q holds the tile under the current slot.
    assign dying         = alive_snap_reg[idx_reg] && ((q != EMPTY_C) || out_of_bounds || head_on);

    trail_collide #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .ADDR_W      (AW),
        .IDX_W       (IW)
    ) u_collide (
        .pos_snap   (pos_snap_reg),
        .alive_snap (alive_snap_reg),
        .idx        (idx_reg),
        .head_on    (head_on)
    );

    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_tiles
            assign tiles[slot_lsb(gi, TW) +: TW] = tiles_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg         <= ST_IDLE;
            idx_reg           <= '0;
            pos_snap_reg      <= '0;
            alive_snap_reg    <= '0;
            clear_pending_reg <= 1'b0;
            address           <= '0;
            data              <= '0;
            wren              <= 1'b0;
            kill              <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            overrun           <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) tiles_reg[i] <= '0;
        end else begin
            done <= 1'b0;
            kill <= '0;
            if (clear_req) clear_pending_reg <= 1'b1;
            if (tick && state_reg != ST_IDLE) overrun <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (tick) begin
                        pos_snap_reg   <= pos;
                        alive_snap_reg <= alive;
                        idx_reg        <= '0;
                        address        <= pos[AW-1:0];
                        wren           <= 1'b0;
                        busy           <= 1'b1;
                        state_reg      <= ST_RD;
                    end else if (clear_pending_reg) begin
                        // A request arriving on this same edge stays pending.
                        clear_pending_reg <= clear_req;
                        address           <= '0;
                        data              <= EMPTY_C;
                        wren              <= 1'b1;
                        busy              <= 1'b1;
                        for (int i = 0; i < NUM_PLAYERS; i++) tiles_reg[i] <= '0;
                        state_reg         <= ST_CLR;
                    end
                end
                ST_RD: state_reg <= ST_CK;
                ST_CK: begin
                    if (dying) begin
                        kill[idx_reg] <= 1'b1;
                    end else if (alive_snap_reg[idx_reg]) begin
                        wren <= 1'b1;
                        data <= COLOUR_BITS'(idx_reg) + COLOUR_BITS'(1);
                        if (tiles_reg[idx_reg] != '1)
                            tiles_reg[idx_reg] <= tiles_reg[idx_reg] + TW'(1);
                    end
                    state_reg <= ST_WR;
                end
                ST_WR: begin
                    wren <= 1'b0;
                    if (idx_reg == LAST) begin
                        done      <= 1'b1;
                        state_reg <= ST_NEXT;
                    end else begin
                        idx_reg   <= idx_next;
                        address   <= pos_snap_reg[idx_next*AW +: AW];
                        state_reg <= ST_RD;
                    end
                end
                ST_NEXT: begin
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                ST_CLR: begin
                    // Sweep {x,y} with y as the inner index.
                    if (address[Y_BITS-1:0] == Y_LIM) begin
                        if (address[AW-1 -: X_BITS] == X_LIM) begin
                            wren      <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= ST_NEXT;
                        end else begin
                            address <= {address[AW-1 -: X_BITS] + X_BITS'(1), Y_BITS'(0)};
                        end
                    end else begin
                        address[Y_BITS-1:0] <= address[Y_BITS-1:0] + Y_BITS'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trail_ram_arbiter.sv
// Directed bench for trail_ram_arbiter with a behavioural registered-read tile RAM.
module tb_trail_ram_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b0;
    logic        tick     = 1'b0;
    logic        clear_req = 1'b0;
    logic [59:0] pos      = '0;
    logic [3:0]  alive    = '0;
    logic [14:0] address;
    logic [2:0]  data;
    logic        wren;
    logic [2:0]  q = '0;
    logic [3:0]  kill;
    logic [63:0] tiles;
    logic        busy;
    logic        done;
    logic        overrun;

    logic [2:0] mem [32768];
    int wr_count = 0, wr_zero = 0, wr_nonzero = 0, wr_oob = 0;
    int err_cnt = 0, chk_cnt = 0;
    int kill_cyc [4];

    always #10 CLOCK_50 = ~CLOCK_50;

    trail_ram_arbiter dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .tick      (tick),
        .clear_req (clear_req),
        .pos       (pos),
        .alive     (alive),
        .address   (address),
        .data      (data),
        .wren      (wren),
        .q         (q),
        .kill      (kill),
        .tiles     (tiles),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    // Single-port RAM: read returns the old contents one cycle after the address edge.
    always @(posedge CLOCK_50) begin
        q <= mem[address];
        if (wren) begin
            mem[address] = data;
            wr_count++;
            if (data == 3'd0) wr_zero++; else wr_nonzero++;
            if (address[14:7] > 8'd159) wr_oob++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic int ad(input int x, input int y);
        return (x << 7) | y;
    endfunction

    function automatic int tile_of(input int i);
        return int'(tiles[i*16 +: 16]);
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) mem[i] = 3'd0;
    endtask

    task automatic set_pos(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int x3, input int y3);
        pos[0*15 +: 15]  = 15'(ad(x0, y0));
        pos[1*15 +: 15]  = 15'(ad(x1, y1));
        pos[2*15 +: 15]  = 15'(ad(x2, y2));
        pos[3*15 +: 15]  = 15'(ad(x3, y3));
    endtask

    // Pulse tick, then observe 30 cycles; cycle 1 is the one right after the sampling edge.
    task automatic run_pass(output int done_cyc, output int busy_cnt, output logic [3:0] kill_acc);
        done_cyc = -1; busy_cnt = 0; kill_acc = '0;
        for (int i = 0; i < 4; i++) kill_cyc[i] = -1;
        @(negedge CLOCK_50); tick = 1'b1;
        @(negedge CLOCK_50); tick = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (busy) busy_cnt++;
            if (done && done_cyc < 0) done_cyc = c;
            for (int i = 0; i < 4; i++)
                if (kill[i] && kill_cyc[i] < 0) kill_cyc[i] = c;
            kill_acc |= kill;
            @(negedge CLOCK_50);
        end
    endtask

    int dc, bc, w0, z0, n0, ndone, first_done, second_done;
    logic [3:0] ka;

    initial begin
        clear_mem();
        repeat (3) @(negedge CLOCK_50);
        check_val("reset_wren", 32'(wren), 0);
        check_val("reset_busy", 32'(busy), 0);
        check_val("reset_address", 32'(address), 0);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        check_val("idle_tiles_lo", tiles[31:0], 0);
        check_val("idle_overrun", 32'(overrun), 0);
        check_val("idle_done", 32'(done), 0);

        // 1: four live slots on an empty grid
        set_pos(10, 10, 20, 20, 30, 30, 40, 40); alive = 4'hF;
        w0 = wr_count;
        run_pass(dc, bc, ka);
        check_val("t1_done_cycle", dc, 13);
        check_val("t1_busy_cycles", bc, 13);
        check_val("t1_kill", 32'(ka), 0);
        check_val("t1_writes", wr_count - w0, 4);
        check_val("t1_mem_s0", 32'(mem[ad(10, 10)]), 1);
        check_val("t1_mem_s1", 32'(mem[ad(20, 20)]), 2);
        check_val("t1_mem_s2", 32'(mem[ad(30, 30)]), 3);
        check_val("t1_mem_s3", 32'(mem[ad(40, 40)]), 4);
        check_val("t1_tiles0", tile_of(0), 1);
        check_val("t1_tiles3", tile_of(3), 1);

        // 2: occupied tile under slot 1
        clear_mem(); mem[ad(20, 20)] = 3'd3;
        w0 = wr_count;
        run_pass(dc, bc, ka);
        check_val("t2_kill", 32'(ka), 32'b0010);
        check_val("t2_kill_cycle", kill_cyc[1], 6);
        check_val("t2_tile_kept", 32'(mem[ad(20, 20)]), 3);
        check_val("t2_writes", wr_count - w0, 3);
        check_val("t2_tiles1", tile_of(1), 1);
        check_val("t2_tiles2", tile_of(2), 2);

        // 3: head-on between slots 0 and 2
        clear_mem(); set_pos(5, 5, 20, 20, 5, 5, 40, 40);
        w0 = wr_count;
        run_pass(dc, bc, ka);
        check_val("t3_kill", 32'(ka), 32'b0101);
        check_val("t3_mem_55", 32'(mem[ad(5, 5)]), 0);
        check_val("t3_mem_s1", 32'(mem[ad(20, 20)]), 2);
        check_val("t3_mem_s3", 32'(mem[ad(40, 40)]), 4);
        check_val("t3_writes", wr_count - w0, 2);

        // 4: slot 3 beyond the right edge
        clear_mem(); set_pos(10, 10, 20, 20, 30, 30, 160, 40);
        w0 = wr_count;
        run_pass(dc, bc, ka);
        check_val("t4_kill", 32'(ka), 32'b1000);
        check_val("t4_kill_cycle", kill_cyc[3], 12);
        check_val("t4_oob_writes", wr_oob, 0);
        check_val("t4_writes", wr_count - w0, 3);
        check_val("t4_tiles0", tile_of(0), 3);

        // 5: second tick while busy, plus a clear request mid-pass
        clear_mem(); set_pos(10, 10, 20, 20, 30, 30, 40, 40);
        z0 = wr_zero; n0 = wr_nonzero;
        ndone = 0; first_done = -1; second_done = -1;
        @(negedge CLOCK_50); tick = 1'b1;
        @(negedge CLOCK_50); tick = 1'b0;
        for (int c = 1; c <= 19300; c++) begin
            tick      = (c == 4);
            clear_req = (c == 6);
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            @(negedge CLOCK_50);
        end
        tick = 1'b0; clear_req = 1'b0;
        check_val("t5_overrun", 32'(overrun), 1);
        check_val("t5_pass_writes", wr_nonzero - n0, 4);
        check_val("t5_first_done", first_done, 13);
        check_val("t5_clear_writes", wr_zero - z0, 19200);
        check_val("t5_clear_done", second_done, 19215);
        check_val("t5_done_count", ndone, 2);
        check_val("t5_mem_cleared", 32'(mem[ad(40, 40)]), 0);
        check_val("t5_tiles_cleared", tiles[31:0], 0);
        check_val("t5_busy_after", 32'(busy), 0);

        // 6: reset in the middle of a clear sweep
        clear_req = 1'b1;
        @(negedge CLOCK_50); clear_req = 1'b0;
        repeat (50) @(negedge CLOCK_50);
        check_val("t6_clr_active", 32'(wren), 1);
        mem[ad(100, 100)] = 3'd5;
        w0 = wr_count;
        resetn = 1'b0;
        #1;
        check_val("t6_wren_reset", 32'(wren), 0);
        check_val("t6_busy_reset", 32'(busy), 0);
        check_val("t6_overrun_reset", 32'(overrun), 0);
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        check_val("t6_no_writes", wr_count - w0, 0);
        check_val("t6_mem_untouched", 32'(mem[ad(100, 100)]), 5);
        check_val("t6_idle_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
